serial_rx_fifo: RTL and testbench

//  UART receive front end for the serial_fpga HBA bridge: 2-flop synchronises rxd, frames 8N1 bytes by
//  mid-bit sampling and buffers them in a small FIFO. Presents bytes to the bridge's command decoder on
//  a valid/ready interface. Framing and overrun errors are reported as sticky status bits.

---
 rtl/serial_rx_pkg.sv | 14 +
 rtl/hba_sync_fifo.sv | 73 +++++++
 rtl/serial_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_serial_rx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive path: frame width and receiver FSM encoding.
package serial_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

endpackage

// File: rtl/hba_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is presented whenever the FIFO is non-empty.
module hba_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Gated so the output reads zero rather than stale storage while empty.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// UART 8N1 receive front end: rxd synchroniser, mid-bit sampling framer, byte FIFO and sticky errors.
//
// state     | meaning
// WAIT_HIGH | line must return high before a start bit is accepted
// IDLE      | line idle high, watching for a falling edge
// START     | timing to start-bit centre to reject glitches
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | sampling the stop bit; high pushes the byte, low flags a framing error
module serial_rx_fifo
  import serial_rx_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          hba_clk,
  input  logic                          hba_reset,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(HALF_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e           state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                rxd_s;
  logic                fifo_push;
  logic                frame_set;
  logic                overrun_set;
  logic                fifo_full;
  logic                fifo_empty;

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_push = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      WAIT_HIGH: begin
        baud_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      IDLE: begin
        baud_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rxd_s) begin
            fifo_push = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = WAIT_HIGH;
      end
    endcase
  end

  // Overrun only when the byte is really lost, i.e. no pop frees a slot this cycle.
  assign overrun_set = fifo_push & fifo_full & ~(rx_ready & ~fifo_empty);

  // A new error outranks a simultaneous clear so no event goes unreported.
  always_comb begin
    frame_err_d = frame_set   | (frame_err_q & ~err_clr);
    overrun_d   = overrun_set | (overrun_q   & ~err_clr);
  end

  always_ff @(posedge hba_clk) begin
    if (!hba_reset) begin
      state_q     <= WAIT_HIGH;
      sync_q      <= 2'b11;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  hba_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (hba_clk),
    .rst_n     (hba_reset),
    .push      (fifo_push),
    .push_data (shift_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo at a reduced line rate (104 clocks per bit) to keep runs short.
module tb_serial_rx_fifo;
  import serial_rx_pkg::*;

  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD_R = 96_000;
  localparam int CPB    = CLK_HZ / BAUD_R;        // 104
  localparam int HALF   = CPB / 2;                // 52
  localparam int LAT    = 2 + HALF + 9*CPB + 1;   // 991

  logic       clk = 1'b0;
  logic       hba_reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] fifo_count;
  logic       err_clr;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  logic valid_prev = 1'b0;

  serial_rx_fifo #(
    .CLK_FREQUENCY (CLK_HZ),
    .BAUD          (BAUD_R),
    .FIFO_DEPTH    (8)
  ) dut (
    .hba_clk    (clk),
    .hba_reset  (hba_reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rxd at the stop-bit level so a low stop can run straight into a held break.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    start_cyc = cyc;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(CPB);
    end
    rxd = stop_bit;
    wait_clks(CPB);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_d, input int exp_cnt);
    check({tag, "_data"}, 32'(rx_data), 32'(exp_d));
    check({tag, "_cnt"}, 32'(fifo_count), 32'(exp_cnt));
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
  endtask

  task automatic err_clr_pulse();
    err_clr = 1'b1;
    wait_clks(1);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    hba_reset = 1'b0;
    rxd       = 1'b1;
    rx_ready  = 1'b0;
    err_clr   = 1'b0;
    wait_clks(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    hba_reset = 1'b1;
    wait_clks(5);

    // 1: single byte, latency from start edge
    send_frame(8'hA5, 1'b1);
    check("t1_latency_ok", 32'((rise_cyc - start_cyc >= LAT - 1) && (rise_cyc - start_cyc <= LAT + 1)), 32'd1);
    check("t1_valid", 32'(rx_valid), 32'd1);
    pop_check("t1", 8'hA5, 1);
    check("t1_empty", 32'(rx_valid), 32'd0);
    wait_clks(10);

    // 2: back-to-back bytes, one pop per cycle
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    pop_check("t2_b0", 8'h00, 3);
    pop_check("t2_b1", 8'hFF, 2);
    pop_check("t2_b2", 8'h55, 1);
    check("t2_cnt0", 32'(fifo_count), 32'd0);
    check("t2_valid0", 32'(rx_valid), 32'd0);
    check("t2_ferr", 32'(frame_err), 32'd0);
    check("t2_ovr", 32'(overrun), 32'd0);
    wait_clks(10);

    // 3: short low glitch is rejected at start-bit centre
    rxd = 1'b0;
    wait_clks(HALF / 2);
    rxd = 1'b1;
    wait_clks(2 * CPB);
    check("t3_cnt", 32'(fifo_count), 32'd0);
    check("t3_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h3C, 1'b1);
    pop_check("t3", 8'h3C, 1);
    wait_clks(10);

    // 4: framing error, held break, recovery
    send_frame(8'h12, 1'b0);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_cnt", 32'(fifo_count), 32'd0);
    wait_clks(20 * CPB);
    check("t4_break_cnt", 32'(fifo_count), 32'd0);
    rxd = 1'b1;
    wait_clks(2 * CPB);
    send_frame(8'h34, 1'b1);
    check("t4_cnt1", 32'(fifo_count), 32'd1);
    check("t4_ferr_held", 32'(frame_err), 32'd1);
    err_clr_pulse();
    check("t4_ferr_clr", 32'(frame_err), 32'd0);
    check("t4_clr_keeps_fifo", 32'(fifo_count), 32'd1);
    pop_check("t4", 8'h34, 1);
    wait_clks(10);

    // 5a: fill, then overrun drops the ninth byte
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    check("t5_full_cnt", 32'(fifo_count), 32'd8);
    check("t5_no_ovr", 32'(overrun), 32'd0);
    send_frame(8'h09, 1'b1);
    check("t5_ovr", 32'(overrun), 32'd1);
    check("t5_ovr_cnt", 32'(fifo_count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_check("t5_drain", 8'(i), 9 - i);
    check("t5_drained", 32'(rx_valid), 32'd0);
    err_clr_pulse();
    check("t5_ovr_clr", 32'(overrun), 32'd0);

    // 5b: full FIFO with a pop on the push cycle loses nothing
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    check("t5b_full_cnt", 32'(fifo_count), 32'd8);
    fork
      send_frame(8'h09, 1'b1);
      begin
        wait_clks(LAT - 1);
        check("t5b_push_align", 32'(dut.fifo_push), 32'd1);
        check("t5b_head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    check("t5b_no_ovr", 32'(overrun), 32'd0);
    check("t5b_cnt", 32'(fifo_count), 32'd8);
    for (int i = 2; i <= 9; i++) pop_check("t5b_drain", 8'(i), 10 - i);
    check("t5b_empty", 32'(rx_valid), 32'd0);
    wait_clks(10);

    // 6: reset mid-frame with bytes queued, line held low across release
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    send_frame(8'hC3, 1'b1);
    check("t6_queued", 32'(fifo_count), 32'd3);
    b = 8'h77;
    rxd = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      wait_clks(CPB);
    end
    check("t6_in_data", 32'(dut.state_q), 32'(DATA));
    rxd = 1'b0;
    wait_clks(HALF);
    hba_reset = 1'b0;
    wait_clks(1);
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'd0);
    check("t6_rst_cnt", 32'(fifo_count), 32'd0);
    check("t6_rst_ferr", 32'(frame_err), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    hba_reset = 1'b1;
    wait_clks(20 * CPB);
    check("t6_low_no_byte", 32'(fifo_count), 32'd0);
    rxd = 1'b1;
    wait_clks(2 * CPB);
    send_frame(8'h81, 1'b1);
    pop_check("t6", 8'h81, 1);
    check("t6_empty", 32'(rx_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
